program_ram_loader: RTL and testbench

- Writable replacement for the fixed program store; it is the writer end of the CPU instruction-fetch interface.
- Accepts a stream of 4-bit opcodes over a valid/ready handshake and writes them sequentially into an internal program RAM.
- The CPU reads the RAM through the same combinational address-in / opcode-out port it uses for a program ROM.
- Holds the CPU idle while the memory is being cleared or loaded.

---
 rtl/program_ram_loader.sv | 198 +++++++++++++++++++
 tb/tb_program_ram_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_ram_loader.sv
// program_ram_loader
//   Writable program store. This block is the writer end of the CPU
//   instruction-fetch interface. A valid/ready stream of 4-bit opcodes is
//   written sequentially into an internal nibble RAM. The CPU reads that RAM
//   through a combinational address-in / opcode-out port, the same port it
//   uses for a program ROM. Every load first clears the whole memory to
//   FILL_OPCODE. The CPU is held while a clear or a load is in progress.
//
// Parameters
//   ADDR_WIDTH   program address width; DEPTH = 2**ADDR_WIDTH nibbles
//   FILL_OPCODE  value written on clear and driven while the CPU is held
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   loadStartIn   request a new load (sampled only in IDLE)
//   dataValidIn   loader stream: opcode valid
//   dataIn        loader stream: opcode nibble
//   dataLastIn    loader stream: final nibble marker
//   dataReadyOut  loader stream: ready (high only in LOAD)
//   addressIn     CPU fetch address
//   dataOut       CPU fetch opcode (combinational)
//   cpuHoldOut    CPU must stall / stay in reset
//   loadBusyOut   clear or load in progress
//   loadDoneOut   one-cycle pulse when a load completes
//   wordCountOut  nibbles accepted in the last load
//   checksumOut   XOR of accepted nibbles (only with PROGRAM_LOADER_CHECKSUM_EN)
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN

module program_ram_loader #(
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [3:0] FILL_OPCODE = 4'b0111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadStartIn,
  input  logic                  dataValidIn,
  input  logic [3:0]            dataIn,
  input  logic                  dataLastIn,
  output logic                  dataReadyOut,
  input  logic [ADDR_WIDTH-1:0] addressIn,
  output logic [3:0]            dataOut,
  output logic                  cpuHoldOut,
  output logic                  loadBusyOut,
  output logic                  loadDoneOut,
  output logic [ADDR_WIDTH:0]   wordCountOut
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic [3:0]            checksumOut
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clearPtr_q, clearPtr_d;
  logic [ADDR_WIDTH-1:0] writePtr_q, writePtr_d;
  logic [ADDR_WIDTH:0]   wordCount_q, wordCount_d;
  logic                  loadPending_q, loadPending_d;

  logic [3:0]            mem_q [DEPTH];

  logic                  accept;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memWaddr;
  logic [3:0]            memWdata;

  // Reset masks the handshake so that a beat presented in the reset cycle is
  // neither written nor counted.
  assign dataReadyOut = (state_q == ST_LOAD) && !reset;
  assign accept       = dataReadyOut && dataValidIn;

  assign cpuHoldOut   = reset || (state_q != ST_IDLE);
  assign loadBusyOut  = reset || (state_q == ST_CLEAR) || (state_q == ST_LOAD);
  assign loadDoneOut  = (state_q == ST_DONE) && !reset;
  assign wordCountOut = wordCount_q;

  // The hold masks the read, so a fetch can never see a location that is
  // being written in the same cycle.
  assign dataOut = cpuHoldOut ? FILL_OPCODE : mem_q[addressIn];

  // Single RAM write port shared by the clear sweep and the load stream.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = clearPtr_q;
    memWdata = FILL_OPCODE;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        memWe = 1'b1;
      end else if (accept) begin
        memWe    = 1'b1;
        memWaddr = writePtr_q;
        memWdata = dataIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memWaddr] <= memWdata;
    end
  end

  // Next-state logic. loadPending remembers whether the current clear was
  // started by a load request (continue into LOAD) or by reset (go to IDLE).
  always_comb begin
    state_d       = state_q;
    clearPtr_d    = clearPtr_q;
    writePtr_d    = writePtr_q;
    wordCount_d   = wordCount_q;
    loadPending_d = loadPending_q;
    unique case (state_q)
      ST_CLEAR: begin
        clearPtr_d = clearPtr_q + 1'b1;
        if (&clearPtr_q) begin
          state_d       = loadPending_q ? ST_LOAD : ST_IDLE;
          loadPending_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (loadStartIn) begin
          state_d       = ST_CLEAR;
          loadPending_d = 1'b1;
          clearPtr_d    = '0;
          writePtr_d    = '0;
          wordCount_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          writePtr_d  = writePtr_q + 1'b1;
          wordCount_d = wordCount_q + 1'b1;
          // A full memory ends the load even without a last marker.
          if (dataLastIn || (&writePtr_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clearPtr_q    <= '0;
      writePtr_q    <= '0;
      wordCount_q   <= '0;
      loadPending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clearPtr_q    <= clearPtr_d;
      writePtr_q    <= writePtr_d;
      wordCount_q   <= wordCount_d;
      loadPending_q <= loadPending_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [3:0] checksum_q, checksum_d;

  // Running XOR of accepted nibbles, restarted by an accepted load request.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == ST_IDLE) && loadStartIn) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q ^ dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksumOut = checksum_q;
`else
  // Checksum tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_program_ram_loader.sv
// Testbench for program_ram_loader. A behavioural model keeps the expected
// memory image as a plain array and tracks accepted beats, count and
// checksum. Inputs are driven and outputs sampled on the falling clock edge.

module tb_program_ram_loader;

  localparam int         AW    = 8;
  localparam int         DEPTH = 1 << AW;
  localparam logic [3:0] FILL  = 4'b0111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          loadStartIn = 1'b0;
  logic          dataValidIn = 1'b0;
  logic [3:0]    dataIn = 4'h0;
  logic          dataLastIn = 1'b0;
  logic          dataReadyOut;
  logic [AW-1:0] addressIn = '0;
  logic [3:0]    dataOut;
  logic          cpuHoldOut;
  logic          loadBusyOut;
  logic          loadDoneOut;
  logic [AW:0]   wordCountOut;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [3:0]    checksumOut;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] modelMem [DEPTH];
  int         modelCount = 0;
  logic [3:0] modelCsum = 4'h0;
  bit         modelLoading = 1'b0;
  bit         doneNext = 1'b0;
  bit         expDone = 1'b0;

  program_ram_loader #(
    .ADDR_WIDTH  (AW),
    .FILL_OPCODE (FILL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .loadStartIn  (loadStartIn),
    .dataValidIn  (dataValidIn),
    .dataIn       (dataIn),
    .dataLastIn   (dataLastIn),
    .dataReadyOut (dataReadyOut),
    .addressIn    (addressIn),
    .dataOut      (dataOut),
    .cpuHoldOut   (cpuHoldOut),
    .loadBusyOut  (loadBusyOut),
    .loadDoneOut  (loadDoneOut),
    .wordCountOut (wordCountOut)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    .checksumOut  (checksumOut)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = FILL;
    modelCount = 0;
    modelCsum  = 4'h0;
  endtask

  // Pulse reset for one cycle, then expect exactly DEPTH held cycles.
  task automatic doReset();
    int  n;
    bit  doneSeen;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    dataValidIn = 1'b0;
    dataLastIn  = 1'b0;
    loadStartIn = 1'b0;
    modelClear();
    modelLoading = 1'b0;
    doneNext     = 1'b0;
    checkOutput("rstCount", wordCountOut, 0);
    checkOutput("rstReady", dataReadyOut, 0);
    checkOutput("rstBusy", loadBusyOut, 1);
    n = 0;
    doneSeen = 1'b0;
    while (cpuHoldOut && n < DEPTH + 20) begin
      doneSeen |= loadDoneOut;
      n++;
      @(negedge clk);
    end
    checkOutput("rstClearLen", n, DEPTH);
    checkOutput("rstNoDone", doneSeen, 0);
    checkOutput("rstIdleBusy", loadBusyOut, 0);
    checkOutput("rstCountAfter", wordCountOut, 0);
  endtask

  // Request a load and wait out the DEPTH-cycle clear.
  task automatic startLoad();
    int n;
    @(negedge clk);
    checkOutput("preStartCount", wordCountOut, modelCount);
    loadStartIn = 1'b1;
    @(negedge clk);
    loadStartIn = 1'b0;
    modelClear();
    checkOutput("startHold", cpuHoldOut, 1);
    checkOutput("startBusy", loadBusyOut, 1);
    checkOutput("startCount", wordCountOut, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("startCsum", checksumOut, 0);
`endif
    n = 0;
    while (!dataReadyOut && n < DEPTH + 20) begin
      n++;
      dataValidIn = 1'($urandom);
      dataIn      = 4'($urandom);
      @(negedge clk);
    end
    dataValidIn = 1'b0;
    checkOutput("loadClearLen", n, DEPTH);
    modelLoading = 1'b1;
    doneNext     = 1'b0;
  endtask

  // One cycle: check what the previous edges produced, then drive a beat.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l);
    logic expHold;
    @(negedge clk);
    expDone  = doneNext;
    doneNext = 1'b0;
    expHold  = modelLoading || expDone;
    checkOutput("done", loadDoneOut, expDone);
    checkOutput("ready", dataReadyOut, modelLoading);
    checkOutput("hold", cpuHoldOut, expHold);
    checkOutput("busy", loadBusyOut, modelLoading);
    checkOutput("count", wordCountOut, modelCount);
    checkOutput("fetch", dataOut, expHold ? FILL : modelMem[addressIn]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("csum", checksumOut, modelCsum);
`endif
    loadStartIn = modelLoading && ($urandom_range(3) == 0);
    dataValidIn = v;
    dataIn      = d;
    dataLastIn  = l;
    addressIn   = AW'($urandom);
    if (v && modelLoading) begin
      modelMem[modelCount] = d;
      modelCount++;
      modelCsum ^= d;
      if (l || modelCount == DEPTH) begin
        modelLoading = 1'b0;
        doneNext     = 1'b1;
      end
    end
  endtask

  task automatic drainLoad();
    int g = 0;
    while ((modelLoading || doneNext) && g < 64) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      g++;
    end
    checkOutput("drainBound", (g < 64), 1);
    applyStimulus(1'b0, 4'h0, 1'b0);
  endtask

  task automatic readAll();
    for (int a = 0; a < DEPTH; a++) begin
      addressIn = AW'(a);
      #1;
      checkOutput($sformatf("rd%0d", a), dataOut, modelMem[a]);
    end
  endtask

  initial begin
    int k;
    $display("[TB] start");

    // After-reset clear
    doReset();
    readAll();

    // Load and fetch
    startLoad();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b1010, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b1);
    drainLoad();
    checkOutput("fetchCount", wordCountOut, 4);
    addressIn = 8'd2;
    #1 checkOutput("fetchAddr2", dataOut, 4'b1010);
    addressIn = 8'd4;
    #1 checkOutput("fetchAddr4", dataOut, FILL);
    readAll();

    // Back-pressure
    startLoad();
    applyStimulus(1'b1, 4'b0101, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b1110, 1'b0);
    applyStimulus(1'b1, 4'b1100, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b1);
    drainLoad();
    checkOutput("bpCount", wordCountOut, 3);
    readAll();

    // Overflow: the full memory ends the load, extra beats are dropped
    startLoad();
    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b1, 4'($urandom), 1'b0);
    drainLoad();
    checkOutput("ovfCount", wordCountOut, DEPTH);
    readAll();

    // Reset mid-load
    startLoad();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'($urandom), 1'b0);
    doReset();
    readAll();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum
    startLoad();
    applyStimulus(1'b1, 4'b1010, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("csumAtDone", checksumOut, 4'b1111);
    drainLoad();
    startLoad();
    drainLoad();
`endif

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      startLoad();
      k = 0;
      while (modelLoading && k < 3000) begin
        applyStimulus(($urandom_range(2) != 0), 4'($urandom), ($urandom_range(39) == 0));
        k++;
      end
      drainLoad();
      readAll();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
